// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader that assembles little-endian words into program memory
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IW = $clog2(MEMORY_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         index_q, index_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            lane_q, lane_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]            chk_q, chk_d;

  logic                  xfer;
  logic [IW-1:0]         index_inc;
  logic [15:0]           len_rx;

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign xfer       = byte_valid && byte_ready;
  assign index_inc  = index_q + IW'(1);
  assign len_rx     = {byte_in, len_q[7:0]};

  assign wr_en      = (state_q == S_WRITE);
  assign wr_address = {{(DATA_WIDTH-IW-2){1'b0}}, index_q, 2'b00};
  assign wr_data    = word_q;
  assign busy       = byte_ready || (state_q == S_WRITE);
  assign cpu_hold   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    len_d   = len_q;
    lane_d  = lane_q;
    word_d  = word_q;
    chk_d   = chk_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          index_d = '0;
          lane_d  = '0;
          chk_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, byte_in};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_rx;
          if (len_rx > 16'(MEMORY_DEPTH)) begin
            state_d = S_ERROR;
          end else if (len_rx == 16'h0000) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{lane_q, 3'b000} +: 8] = byte_in;
          chk_d  = chk_q ^ byte_in;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The memory strobe sees index_q this cycle; it advances on the way out.
        index_d = index_inc;
        if ({{(16-IW){1'b0}}, index_inc} == len_q) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_d = (byte_in == chk_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      len_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      chk_q   <= chk_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized and directed self-checking bench for program_loader
module tb_program_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];
  int          ready_in_write = 0;

  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every memory write seen mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (wr_en) begin
      mon_addr.push_back(wr_address);
      mon_data.push_back(wr_data);
      mon_cyc.push_back(cyc);
      if (byte_ready) ready_in_write++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    ready_in_write = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
    bit got;
    got = 1'b0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    if (mid_start) start = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = byte_ready;
      tick();
      start = 1'b0;
    end
    if (!got) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_error"},      {31'd0, error},      32'd0);
    check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
    check({tag, "_wr_address"}, wr_address,          32'd0);
    check({tag, "_wr_data"},    wr_data,             32'd0);
  endtask

  // Reference: N words from the stream land at 4*i; success needs N<=DEPTH and a matching XOR.
  task automatic run_load(input int n, input bit good, input int maxgap,
                          input int mid_start_at, input bit valid_with_start);
    logic [7:0]  data[$];
    logic [7:0]  x;
    logic [7:0]  ck;
    logic [15:0] len;
    logic [31:0] exp_word;
    int          nw;
    bit          exp_done;
    ck  = 8'h00;
    len = 16'(n);
    nw  = (n <= DEPTH) ? n : 0;
    data.delete();
    for (int i = 0; i < 4 * nw; i++) begin
      x = 8'($urandom);
      data.push_back(x);
      ck ^= x;
    end
    if (!good) ck ^= 8'($urandom_range(1, 255));
    clear_mon();
    if (valid_with_start) begin
      byte_in    = len[7:0];
      byte_valid = 1'b1;
    end
    pulse_start();
    send_byte(len[7:0],  $urandom_range(0, maxgap), 1'b0);
    send_byte(len[15:8], $urandom_range(0, maxgap), 1'b0);
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * nw; i++)
        send_byte(data[i], $urandom_range(0, maxgap), i == mid_start_at);
      send_byte(ck, $urandom_range(0, maxgap), 1'b0);
    end
    byte_valid = 1'b0;
    tick();
    tick();
    check("write_count", mon_addr.size(), nw);
    for (int i = 0; i < nw && i < mon_addr.size(); i++) begin
      exp_word = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
      check("write_addr", mon_addr[i], 32'(4 * i));
      check("write_data", mon_data[i], exp_word);
      if (maxgap == 0 && i > 0)
        check("write_spacing", mon_cyc[i] - mon_cyc[i-1], 32'd5);
    end
    check("ready_in_write", ready_in_write, 32'd0);
    exp_done = (n <= DEPTH) && good;
    check("done",     {31'd0, done},     {31'd0, exp_done});
    check("error",    {31'd0, error},    {31'd0, !exp_done});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    check("busy",     {31'd0, busy},     32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    reset = 1'b0;
    tick();

    // Single word 0x12345678 with good checksum 0x08.
    clear_mon();
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h78, 0, 1'b0);
    send_byte(8'h56, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    @(negedge clk);
    check("t1_wr_en",       {31'd0, wr_en},      32'd1);
    check("t1_wr_address",  wr_address,          32'h0000_0000);
    check("t1_wr_data",     wr_data,             32'h1234_5678);
    check("t1_ready_write", {31'd0, byte_ready}, 32'd0);
    tick();
    send_byte(8'h08, 0, 1'b0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t1_done",     {31'd0, done},     32'd1);
    check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("t1_error",    {31'd0, error},    32'd0);
    check("t1_writes",   mon_addr.size(),   32'd1);
    tick();

    run_load(3, 1'b1, 0, -1, 1'b0);
    run_load(33, 1'b1, 0, -1, 1'b0);
    run_load(1, 1'b0, 0, -1, 1'b0);
    run_load(1, 1'b1, 1, -1, 1'b0);
    run_load(4, 1'b1, 0, 5, 1'b0);
    run_load(2, 1'b1, 1, -1, 1'b1);
    run_load(0, 1'b1, 0, -1, 1'b0);
    run_load(0, 1'b0, 0, -1, 1'b0);
    run_load(DEPTH, 1'b1, 0, -1, 1'b0);

    // Reset landing on the WRITE cycle.
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    send_byte(8'hCC, 0, 1'b0);
    send_byte(8'hDD, 0, 1'b0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("rst_in_write", {31'd0, wr_en}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_write");
    tick();

    for (int k = 0; k < 8; k++)
      run_load($urandom_range(0, DEPTH + 4), $urandom_range(0, 3) != 0, 2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
